// File: rtl/temp_sensor_3wire_pkg.sv
// Shared types and constants for the 3-wire thermometer acquisition block.
package temp_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    CS_SETUP = 3'd0,
    CMD      = 3'd1,
    READ     = 3'd2,
    CS_END   = 3'd3,
    CONV     = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [7:0] CMD_START_CONV = 8'hEE;
  localparam logic [7:0] CMD_READ_TEMP  = 8'hAA;

  localparam logic signed [8:0] TEMP_MIN = -9'sd55;
  localparam logic signed [8:0] TEMP_MAX = 9'sd125;

  // Half-degree raw reading to whole degrees, rounding toward minus infinity
  function automatic logic [8:0] half_to_whole(input logic [8:0] raw);
    return {raw[8], raw[8:1]};
  endfunction

  // True when a whole-degree value lies outside the sensor's rated range
  function automatic logic out_of_range(input logic [8:0] temp);
    return ($signed(temp) < TEMP_MIN) || ($signed(temp) > TEMP_MAX);
  endfunction

endpackage

// File: rtl/temp_sensor_3wire_serial_bit_timer.sv
// Serial bit timer: divides clk into bit slots of 2*CLK_DIV cycles and
// emits strobes at the start of the low phase, at the sample point and at
// the last cycle of the bit. Counting restarts whenever run is low.
module serial_bit_timer #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic low_start,
  output logic sample,
  output logic bit_done
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] LAST_CNT   = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(CLK_DIV);

  logic [CW-1:0] cnt;

  // Position within the current bit slot; wraps at the end of each bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || (cnt == LAST_CNT)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // The sequencer registers the pin levels, so a strobe at count N shows
  // on the pins from count N+1; the sample point is the last low cycle.
  assign low_start = run && (cnt == '0);
  assign sample    = run && (cnt == SAMPLE_CNT);
  assign bit_done  = run && (cnt == LAST_CNT);

endmodule

// File: rtl/temp_sensor_3wire.sv
// DS1620-style 3-wire thermometer reader: one start-convert after reset,
// then periodic 9-bit reads converted to signed whole degrees.
module temp_sensor_3wire
  import temp_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int CONV_WAIT  = 37_500_000,
  parameter int SAMPLE_GAP = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sen_rst_n,
  output logic       sen_clk,
  output logic       dq_out,
  output logic       dq_oe,
  input  logic       dq_in,
  output logic [8:0] temperature,
  output logic       temp_valid,
  output logic       range_err,
  output logic       busy
);

  localparam logic [31:0] DIV_LOAD  = 32'(CLK_DIV - 1);
  localparam logic [31:0] CONV_LOAD = 32'(CONV_WAIT - 1);
  localparam logic [31:0] GAP_LOAD  = 32'(SAMPLE_GAP - 1);

  state_t      state, state_n;
  logic [31:0] wait_cnt, wait_n;
  logic [3:0]  bit_idx, bit_n;
  logic [8:0]  shift, shift_n;
  logic        conv_pending, conv_pending_n;
  logic        dq_meta, dq_sync;
  logic        run_s, low_start_s, sample_s, bit_done_s;
  logic [7:0]  cmd_s;
  logic [8:0]  whole_s;
  logic        sclk_n, dq_out_n, dq_oe_n, valid_n, rerr_n, cs_n, busy_n;
  logic [8:0]  temp_n;

  assign run_s   = (state == CMD) || (state == READ);
  assign cmd_s   = conv_pending ? CMD_START_CONV : CMD_READ_TEMP;
  assign whole_s = half_to_whole(shift);

  serial_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run_s),
    .low_start (low_start_s),
    .sample    (sample_s),
    .bit_done  (bit_done_s)
  );

  // Two-flop synchronizer for the asynchronous DQ input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_meta <= 1'b0;
      dq_sync <= 1'b0;
    end else begin
      dq_meta <= dq_in;
      dq_sync <= dq_meta;
    end
  end

  // Next-state, shift and next-output logic for the transaction sequencer
  always_comb begin
    state_n        = state;
    wait_n         = wait_cnt;
    bit_n          = bit_idx;
    shift_n        = shift;
    conv_pending_n = conv_pending;
    sclk_n         = sen_clk;
    dq_out_n       = dq_out;
    dq_oe_n        = dq_oe;
    temp_n         = temperature;
    valid_n        = 1'b0;
    rerr_n         = range_err;
    case (state)
      CS_SETUP: begin
        sclk_n  = 1'b1;
        dq_oe_n = 1'b0;
        if (wait_cnt == 32'd0) begin
          state_n = CMD;
          bit_n   = 4'd0;
        end else begin
          wait_n = wait_cnt - 32'd1;
        end
      end
      CMD: begin
        if (low_start_s) begin
          sclk_n   = 1'b0;
          dq_oe_n  = 1'b1;
          dq_out_n = cmd_s[bit_idx[2:0]];
        end else if (sample_s) begin
          sclk_n = 1'b1;
        end else if (bit_done_s) begin
          if (bit_idx == 4'd7) begin
            dq_oe_n = 1'b0;
            bit_n   = 4'd0;
            if (conv_pending) begin
              state_n = CS_END;
              wait_n  = DIV_LOAD;
            end else begin
              state_n = READ;
              shift_n = 9'd0;
            end
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end else begin
          bit_n = bit_idx;
        end
      end
      READ: begin
        if (low_start_s) begin
          sclk_n  = 1'b0;
          dq_oe_n = 1'b0;
        end else if (sample_s) begin
          sclk_n  = 1'b1;
          shift_n = {dq_sync, shift[8:1]};
        end else if (bit_done_s) begin
          if (bit_idx == 4'd8) begin
            state_n = CS_END;
            wait_n  = DIV_LOAD;
            temp_n  = whole_s;
            rerr_n  = out_of_range(whole_s);
            valid_n = 1'b1;
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end else begin
          bit_n = bit_idx;
        end
      end
      CS_END: begin
        sclk_n  = 1'b1;
        dq_oe_n = 1'b0;
        if (wait_cnt == 32'd0) begin
          if (conv_pending) begin
            state_n        = CONV;
            wait_n         = CONV_LOAD;
            conv_pending_n = 1'b0;
          end else begin
            state_n = GAP;
            wait_n  = GAP_LOAD;
          end
        end else begin
          wait_n = wait_cnt - 32'd1;
        end
      end
      CONV, GAP: begin
        if (wait_cnt == 32'd0) begin
          state_n = CS_SETUP;
          wait_n  = DIV_LOAD;
        end else begin
          wait_n = wait_cnt - 32'd1;
        end
      end
      default: begin
        state_n = GAP;
        wait_n  = 32'd0;
      end
    endcase
    cs_n   = (state_n == CS_SETUP) || (state_n == CMD) || (state_n == READ);
    busy_n = cs_n || (state_n == CS_END);
  end

  // State, datapath and registered pin outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= GAP;
      wait_cnt     <= 32'd0;
      bit_idx      <= 4'd0;
      shift        <= 9'd0;
      conv_pending <= 1'b1;
      sen_rst_n    <= 1'b0;
      sen_clk      <= 1'b1;
      dq_out       <= 1'b0;
      dq_oe        <= 1'b0;
      temperature  <= 9'd0;
      temp_valid   <= 1'b0;
      range_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      wait_cnt     <= wait_n;
      bit_idx      <= bit_n;
      shift        <= shift_n;
      conv_pending <= conv_pending_n;
      sen_rst_n    <= cs_n;
      sen_clk      <= sclk_n;
      dq_out       <= dq_out_n;
      dq_oe        <= dq_oe_n;
      temperature  <= temp_n;
      temp_valid   <= valid_n;
      range_err    <= rerr_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_temp_sensor_3wire.sv
// Scoreboard bench for temp_sensor_3wire with a behavioural 3-wire sensor.
module tb_temp_sensor_3wire;

  localparam int CLK_DIV    = 4;
  localparam int CONV_WAIT  = 100;
  localparam int SAMPLE_GAP = 200;
  // Busy-high length: setup + end hold, plus 8 command bits (and 9 read bits)
  localparam int CONV_TXN_LEN = 2 * CLK_DIV + 8 * 2 * CLK_DIV;        // 72
  localparam int READ_TXN_LEN = 2 * CLK_DIV + 17 * 2 * CLK_DIV;       // 144
  localparam int NVEC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dq_in = 1'b0;
  logic       sen_rst_n, sen_clk, dq_out, dq_oe;
  logic [8:0] temperature;
  logic       temp_valid, range_err, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nvalid = 0;

  logic [7:0] exp_cmd[$];
  logic [8:0] raw_q[$];
  logic [9:0] exp_q[$];

  // raw half-degree reading, expected whole degrees, expected range flag
  logic [8:0] vec_raw [NVEC] = '{9'h032, 9'h1CE, 9'h1FF, 9'h0FA, 9'h0FC,
                                 9'h192, 9'h190, 9'h18E, 9'h0FF, 9'h100};
  logic [8:0] vec_temp[NVEC] = '{9'h019, 9'h1E7, 9'h1FF, 9'h07D, 9'h07E,
                                 9'h1C9, 9'h1C8, 9'h1C7, 9'h07F, 9'h180};
  logic       vec_rerr[NVEC] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  temp_sensor_3wire #(
    .CLK_DIV    (CLK_DIV),
    .CONV_WAIT  (CONV_WAIT),
    .SAMPLE_GAP (SAMPLE_GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sen_rst_n   (sen_rst_n),
    .sen_clk     (sen_clk),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe),
    .dq_in       (dq_in),
    .temperature (temperature),
    .temp_valid  (temp_valid),
    .range_err   (range_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural sensor: commands latched on sen_clk rise, data driven on fall
  int         s_bit = 0;
  int         r_bit = 0;
  int         s_phase = 0;        // 0 command, 1 reading, 2 idle
  logic [7:0] cmd_sh = 8'h00;
  logic [7:0] last_cmd = 8'h00;
  logic [8:0] cur_raw = 9'h000;

  always @(posedge sen_clk or negedge sen_clk or negedge sen_rst_n) begin
    if (sen_rst_n !== 1'b1) begin
      s_phase = 0;
      s_bit   = 0;
      r_bit   = 0;
    end else if (sen_clk) begin
      if (s_phase == 0) begin
        cmd_sh[s_bit] = dq_out;
        s_bit++;
        if (s_bit == 8) begin
          last_cmd = cmd_sh;
          if (exp_cmd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_unexpected: got %0h expected none", cmd_sh);
          end else begin
            check("cmd", {24'd0, cmd_sh}, {24'd0, exp_cmd.pop_front()});
          end
          if (cmd_sh == 8'hAA) begin
            s_phase = 1;
            r_bit   = 0;
            cur_raw = (raw_q.size() != 0) ? raw_q.pop_front() : 9'h000;
          end else begin
            s_phase = 2;
          end
        end
      end
    end else begin
      if (s_phase == 1) begin
        dq_in = cur_raw[r_bit];
        r_bit++;
        if (r_bit == 9) s_phase = 2;
      end
    end
  end

  // Monitor: scoreboard pops on each strobe, plus pulse/stability/timing checks
  logic       prev_busy = 1'b0, prev_valid = 1'b0, in_txn = 1'b0;
  logic       have_fall = 1'b0, changed = 1'b0;
  logic [8:0] last_t = 9'h000;
  int         rise_c = 0, fall_c = 0, gap_exp = 0;
  logic [9:0] exp_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy  = 1'b0;
      prev_valid = 1'b0;
      in_txn     = 1'b0;
      have_fall  = 1'b0;
      changed    = 1'b0;
      last_t     = 9'h000;
    end else begin
      if (temp_valid) begin
        nvalid++;
        check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
        check("stable_between", {31'd0, changed}, 32'd0);
        check("busy_at_strobe", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got temperature %0h expected no strobe", temperature);
        end else begin
          exp_e = exp_q.pop_front();
          check("temperature", {23'd0, temperature}, {23'd0, exp_e[8:0]});
          check("range_err", {31'd0, range_err}, {31'd0, exp_e[9]});
        end
        last_t  = temperature;
        changed = 1'b0;
      end else if (temperature !== last_t) begin
        changed = 1'b1;
      end
      if (busy && !prev_busy) begin
        if (have_fall) check("gap_len", cyc - fall_c, gap_exp);
        rise_c = cyc;
        in_txn = 1'b1;
      end
      if (!busy && prev_busy && in_txn) begin
        check("txn_len", cyc - rise_c, (last_cmd == 8'hEE) ? CONV_TXN_LEN : READ_TXN_LEN);
        fall_c    = cyc;
        have_fall = 1'b1;
        gap_exp   = (last_cmd == 8'hEE) ? CONV_WAIT : SAMPLE_GAP;
      end
      prev_busy  = busy;
      prev_valid = temp_valid;
    end
  end

  task automatic wait_valid(input string name);
    int start;
    bit seen;
    start = nvalid;
    seen  = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      if (nvalid != start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no temp_valid expected one within 1500 cycles", name);
    end
  endtask

  task automatic push_read(input logic [8:0] raw, input logic [8:0] t, input logic e);
    exp_cmd.push_back(8'hAA);
    raw_q.push_back(raw);
    exp_q.push_back({e, t});
  endtask

  initial begin
    bit hit;
    exp_cmd.push_back(8'hEE);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {17'd0, sen_rst_n, sen_clk, dq_out, dq_oe, temp_valid, range_err, busy, temperature},
          {17'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000});
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      push_read(vec_raw[v], vec_temp[v], vec_rerr[v]);
      wait_valid("read");
    end

    // Abort a read part-way through its data bits
    push_read(9'h064, 9'h032, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      if (s_phase == 1 && r_bit == 5) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL abort_timeout: got no read bit 4 expected one within 1500 cycles");
    end
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs", {19'd0, sen_rst_n, sen_clk, dq_oe, busy, temperature},
          {19'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000});
    exp_q.delete();
    raw_q.delete();
    exp_cmd.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cmd.push_back(8'hEE);
    push_read(9'h1F4, 9'h1FA, 1'b0);
    wait_valid("after_abort");

    repeat (12) @(posedge clk);
    check("queues_drained", exp_q.size() + exp_cmd.size() + raw_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
